// File: rtl/button_array_dev.sv
// button_array_dev: memory-mapped pushbutton input device.
// Each channel is synchronised, debounced and turned into a single press
// event; events collect in a data-register mask and raise a level IRQ.
module button_array_dev #(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] buttons,
    input  logic            dev_sel,
    input  logic            addr,
    input  logic            rd,
    input  logic            wr,
    input  logic [7:0]      wdata,
    output logic [7:0]      rdata,
    output logic            irq
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } db_state_t;

    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [N_CH-1:0] press_c;
    logic [N_CH-1:0] cap_c;
    logic [N_CH-1:0] mask;
    logic            ena;
    logic            ie;
    logic            dba;
    logic            of;

    logic            csr_wr_c;
    logic            csr_rd_c;
    logic            dr_rd_c;
    logic            cap_any_c;
    logic [7:0]      csr_c;
    logic            unused_wdata_c;

    // Two-flop synchroniser for the raw button levels
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= buttons;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        db_state_t        state;
        logic [CNT_W-1:0] cnt;

        // Debounce FSM: a level change is accepted after DEBOUNCE_CYCLES+1 stable samples
        always_ff @(posedge clk) begin
            if (rst) begin
                state <= RELEASED;
                cnt   <= '0;
            end else begin
                case (state)
                    RELEASED: begin
                        if (sync2[i]) begin
                            state <= PRESS_PEND;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    PRESS_PEND: begin
                        if (!sync2[i]) begin
                            state <= RELEASED;
                            cnt   <= '0;
                        end else if (cnt == CNT_MAX) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (!sync2[i]) begin
                            state <= RELEASE_PEND;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    RELEASE_PEND: begin
                        if (sync2[i]) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt == CNT_MAX) begin
                            state <= RELEASED;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        // Press pulse on the edge that moves the FSM into PRESSED
        assign press_c[i] = (state == PRESS_PEND) && sync2[i] && (cnt == CNT_MAX);
    end

    // Bus decode; a simultaneous write suppresses the read
    assign csr_wr_c  = dev_sel & wr & ~addr;
    assign csr_rd_c  = dev_sel & rd & ~wr & ~addr;
    assign dr_rd_c   = dev_sel & rd & ~wr & addr;
    assign cap_c     = ena ? press_c : '0;
    assign cap_any_c = |cap_c;
    assign csr_c     = {3'b000, ena, ie, dba, of, 1'b0};

    // Write-data bits that have no register behind them
    assign unused_wdata_c = ^{wdata[7:5], wdata[2], wdata[0]};

    // CSR, event mask, read data and interrupt registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ena   <= 1'b0;
            ie    <= 1'b0;
            dba   <= 1'b0;
            of    <= 1'b0;
            mask  <= '0;
            rdata <= 8'h00;
            irq   <= 1'b0;
        end else begin
            if (csr_wr_c) begin
                ena <= wdata[4];
                ie  <= wdata[3];
                if (wdata[1]) begin
                    of <= 1'b0;
                end
            end

            // A new event on top of an unread one overruns, unless it is being read now
            if (cap_any_c && dba && !dr_rd_c) begin
                of <= 1'b1;
            end

            if (csr_rd_c) begin
                rdata <= csr_c;
            end else if (dr_rd_c) begin
                rdata <= 8'(mask);
            end

            // A DR read restarts the mask with whatever presses land on the same edge
            if (dr_rd_c) begin
                mask <= cap_c;
                dba  <= cap_any_c;
            end else if (cap_any_c) begin
                mask <= mask | cap_c;
                dba  <= 1'b1;
            end

            irq <= ie & dba;
        end
    end

endmodule
